result_dump_unit: RTL and testbench

- Reader-side companion to the pipelined RSA CPU's data-memory writes.
- After the CPU asserts its end-of-program flag, the block walks a fixed window of data memory: WORD_COUNT words starting at BASE_ADDR.
- It reads each 32-bit word through a dedicated read port with a registered read.
- It streams each word out as four bytes, MSB first, over a valid/ready byte interface toward a UART or host link.

---
 rtl/result_dump_unit.sv | 126 ++++++++++++
 tb/tb_result_dump_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_dump_unit.sv
// Result dump unit: after the CPU raises its end-of-program flag, reads a fixed
// window of data memory one word at a time and streams each word out as four
// bytes, most significant first, over a valid/ready byte link.
module result_dump_unit #(
  parameter logic [31:0] BaseAddr  = 32'h0000_0100,
  parameter int unsigned WordCount = 64,
  parameter int unsigned AddrStep  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        end_flag,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  // StArm is the IDLE-decision cycle; StDoneHold parks the unit until reset.
  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StIssue,
    StWait,
    StSend,
    StNext,
    StFin,
    StDoneHold
  } state_e;

  state_e      state_q;
  logic        flag_q;
  logic        rise_q;
  logic [31:0] word_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] shreg_q;

  // Registered rising-edge detect of the CPU end flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      flag_q <= end_flag;
      rise_q <= end_flag & ~flag_q;
    end
  end

  // Dump sequencer; every output is registered and reflects the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_en      <= 1'b0;
      rd_addr    <= BaseAddr;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_cnt_q <= 32'd0;
      byte_idx_q <= 2'd0;
      shreg_q    <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise_q) begin
            busy    <= 1'b1;
            state_q <= (WordCount == 0) ? StFin : StArm;
          end
        end
        StArm: begin
          rd_en   <= 1'b1;
          rd_addr <= BaseAddr;
          state_q <= StIssue;
        end
        StIssue: begin
          // rd_en was high for exactly this cycle; data returns next cycle.
          rd_en   <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          shreg_q    <= rd_data;
          byte_data  <= rd_data[31:24];
          byte_valid <= 1'b1;
          byte_idx_q <= 2'd0;
          state_q    <= StSend;
        end
        StSend: begin
          // byte_valid is always high here, so byte_ready alone marks a transfer.
          if (byte_ready) begin
            shreg_q    <= shreg_q << 8;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              byte_valid <= 1'b0;
              state_q    <= StNext;
            end else begin
              byte_data <= shreg_q[23:16];
            end
          end
        end
        StNext: begin
          word_cnt_q <= word_cnt_q + 32'd1;
          if (word_cnt_q + 32'd1 == WordCount) begin
            state_q <= StFin;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= rd_addr + AddrStep;
            state_q <= StIssue;
          end
        end
        StFin: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDoneHold;
        end
        StDoneHold: begin
          // Further end_flag edges are ignored until reset.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_dump_unit.sv
// Bench for result_dump_unit: three instances (two-word dump, empty dump,
// two-word dump across the address wrap) share one stimulus stream and are
// checked every cycle against a transaction-level model of the dump.
module tb_result_dump_unit;

  localparam int N = 3;
  localparam logic [31:0] BASES [N] = '{32'h0000_0100, 32'h0000_0100, 32'hFFFF_FFFC};
  localparam int unsigned COUNTS [N] = '{32'd2, 32'd0, 32'd2};

  logic        clk = 1'b0;
  logic        reset;
  logic        end_flag;
  logic        byte_ready;
  logic        rd_en      [N];
  logic [31:0] rd_addr    [N];
  logic [31:0] rd_data    [N];
  logic [7:0]  byte_data  [N];
  logic        byte_valid [N];
  logic        busy       [N];
  logic        done       [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    result_dump_unit #(
      .BaseAddr (BASES[g]),
      .WordCount(COUNTS[g]),
      .AddrStep (4)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .end_flag  (end_flag),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .byte_data (byte_data[g]),
      .byte_valid(byte_valid[g]),
      .byte_ready(byte_ready),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit rst_seen = 1'b1;

  // Transaction model state.
  bit          trig = 1'b0;
  int          trig_cyc = -100;
  bit          last_ef = 1'b0;
  int          rd_cnt      [N];
  int          byte_cnt    [N];
  int          word_end    [N];
  int          last_rd     [N];
  int          busy_cycles [N];
  bit          prev_stall  [N];
  bit          prev_valid  [N];
  bit          prev_done   [N];
  logic [7:0]  prev_data   [N];
  logic [7:0]  cap_bytes   [N][8];
  logic [31:0] cap_addr    [N][2];

  logic [7:0]  lit [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
  logic [15:0] pat = 16'b1001_0110_1001_1001;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'hDEAD_BEEF;
      32'h0000_0104: mem_word = 32'h0123_4567;
      32'hFFFF_FFFC: mem_word = 32'hCAFE_F00D;
      32'h0000_0000: mem_word = 32'h8BAD_F00D;
      default:       mem_word = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input int n);
    logic [31:0] w;
    w = mem_word(BASES[i] + 32'(n / 4) * 32'd4);
    return w[31 - 8 * (n % 4) -: 8];
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    started = 1'b1;
    rst_seen = !reset;
  end

  // Registered-read memory; drives junk whenever no read was issued.
  always begin
    logic        en_s [N];
    logic [31:0] a_s  [N];
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      en_s[i] = rd_en[i];
      a_s[i]  = rd_addr[i];
    end
    #1;
    for (int i = 0; i < N; i++)
      rd_data[i] = en_s[i] ? mem_word(a_s[i]) : (32'hA5A5_0000 | 32'(cyc[15:0]));
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        if (rst_seen) begin
          chk("reset_rd_en", i, 32'(rd_en[i]), 32'd0);
          chk("reset_rd_addr", i, rd_addr[i], BASES[i]);
          chk("reset_byte_data", i, 32'(byte_data[i]), 32'd0);
          chk("reset_byte_valid", i, 32'(byte_valid[i]), 32'd0);
          chk("reset_busy", i, 32'(busy[i]), 32'd0);
          chk("reset_done", i, 32'(done[i]), 32'd0);
        end else begin
          if (rd_en[i]) begin
            chk("rd_limit", i, 32'(rd_cnt[i] < int'(COUNTS[i])), 32'd1);
            chk("rd_addr", i, rd_addr[i], BASES[i] + 32'(rd_cnt[i]) * 32'd4);
            chk("rd_time", i, 32'(cyc), 32'(rd_cnt[i] == 0 ? trig_cyc + 2 : word_end[i] + 1));
            chk("rd_busy", i, 32'(busy[i]), 32'd1);
            if (rd_cnt[i] < 2) cap_addr[i][rd_cnt[i]] = rd_addr[i];
            last_rd[i] = cyc;
            rd_cnt[i]++;
          end
          if (byte_valid[i] && !prev_valid[i])
            chk("bv_time", i, 32'(cyc), 32'(last_rd[i] + 2));
          if (prev_stall[i]) begin
            chk("hold_valid", i, 32'(byte_valid[i]), 32'd1);
            chk("hold_data", i, 32'(byte_data[i]), 32'(prev_data[i]));
          end
          if (byte_valid[i]) begin
            chk("byte_limit", i, 32'(byte_cnt[i] < 4 * int'(COUNTS[i])), 32'd1);
            chk("bv_busy", i, 32'(busy[i]), 32'd1);
            if (byte_ready) begin
              chk("byte_data", i, 32'(byte_data[i]), 32'(exp_byte(i, byte_cnt[i])));
              if (byte_cnt[i] < 8) cap_bytes[i][byte_cnt[i]] = byte_data[i];
              byte_cnt[i]++;
              if (byte_cnt[i] % 4 == 0) word_end[i] = cyc + 1;
            end
          end
          prev_stall[i] = byte_valid[i] && !byte_ready;
          prev_valid[i] = byte_valid[i];
          prev_data[i]  = byte_data[i];
          if (busy[i]) busy_cycles[i]++;
          chk("busy_done_excl", i, 32'(busy[i] && done[i]), 32'd0);
          if (prev_done[i]) chk("done_sticky", i, 32'(done[i]), 32'd1);
          prev_done[i] = done[i];
          if (COUNTS[i] == 0) begin
            chk("zero_busy", i, 32'(busy[i]), 32'(trig && cyc == trig_cyc + 1));
            chk("zero_done", i, 32'(done[i]), 32'(trig && cyc >= trig_cyc + 2));
            chk("zero_rd_en", i, 32'(rd_en[i]), 32'd0);
          end else if (done[i]) begin
            chk("done_after_all", i, 32'(byte_cnt[i]), 32'(4 * COUNTS[i]));
          end
        end
      end
      // Predict what the next clock edge samples.
      if (!reset) begin
        trig = 1'b0;
        trig_cyc = -100;
        last_ef = 1'b0;
        for (int i = 0; i < N; i++) begin
          rd_cnt[i] = 0;
          byte_cnt[i] = 0;
          word_end[i] = -100;
          last_rd[i] = -100;
          busy_cycles[i] = 0;
          prev_stall[i] = 1'b0;
          prev_valid[i] = 1'b0;
          prev_done[i] = 1'b0;
        end
      end else begin
        if (end_flag && !last_ef && !trig) begin
          trig = 1'b1;
          trig_cyc = cyc + 1;
        end
        last_ef = end_flag;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    end_flag = 1'b0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
  endtask

  task automatic pulse_flag();
    end_flag = 1'b1;
    step(1);
    end_flag = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(done[0] && done[1] && done[2]) && n < limit) begin
      step(1);
      n++;
    end
    chk("done_timeout", 0, 32'(done[0] && done[1] && done[2]), 32'd1);
    step(3);
  endtask

  task automatic end_checks();
    for (int i = 0; i < N; i++) begin
      chk("end_done", i, 32'(done[i]), 32'd1);
      chk("end_busy", i, 32'(busy[i]), 32'd0);
      chk("end_rd_cnt", i, 32'(rd_cnt[i]), COUNTS[i]);
      chk("end_byte_cnt", i, 32'(byte_cnt[i]), 32'(4 * COUNTS[i]));
    end
    chk("zero_busy_cycles", 1, 32'(busy_cycles[1]), 32'd1);
    for (int j = 0; j < 8; j++) chk("lit_bytes", 0, 32'(cap_bytes[0][j]), 32'(lit[j]));
    chk("lit_addr0", 0, cap_addr[0][0], 32'h0000_0100);
    chk("lit_addr1", 0, cap_addr[0][1], 32'h0000_0104);
    chk("lit_wrap_addr0", 2, cap_addr[2][0], 32'hFFFF_FFFC);
    chk("lit_wrap_addr1", 2, cap_addr[2][1], 32'h0000_0000);
    chk("lit_wrap_byte0", 2, 32'(cap_bytes[2][0]), 32'h0000_00CA);
    chk("lit_wrap_byte7", 2, 32'(cap_bytes[2][7]), 32'h0000_000D);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    end_flag = 1'b0;
    byte_ready = 1'b1;
    step(3);
    reset = 1'b1;
    step(2);

    // Back-to-back dump with the sink always ready.
    pulse_flag();
    wait_done(300);
    end_checks();

    // Sink applies back-pressure with a fixed irregular pattern.
    do_reset();
    pulse_flag();
    n = 0;
    while (!done[0] && n < 300) begin
      byte_ready = pat[n % 16];
      step(1);
      n++;
    end
    byte_ready = 1'b1;
    wait_done(50);
    end_checks();

    // Held flag gives one dump; a later edge after done is ignored.
    do_reset();
    end_flag = 1'b1;
    step(100);
    end_flag = 1'b0;
    step(5);
    end_flag = 1'b1;
    step(30);
    end_flag = 1'b0;
    step(5);
    end_checks();

    // Reset while the third byte of the second word is on the link, then restart.
    do_reset();
    pulse_flag();
    n = 0;
    while (!(byte_cnt[0] == 6 && byte_valid[0]) && n < 200) begin
      step(1);
      n++;
    end
    chk("reach_mid_word", 0, 32'(byte_cnt[0] == 6 && byte_valid[0]), 32'd1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(3);
    pulse_flag();
    wait_done(300);
    end_checks();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
